lcd_fetch_sched: RTL and testbench
==================================

Name: lcd_fetch_sched

Overview:
Fetch scheduler between the LCD AHB master and the two panel FIFOs (upper = FIFO 1, lower = FIFO 2). It tracks per-panel frame address and remaining word count. It decides which FIFO is refilled next, sizes each burst, and issues one burst request at a time to the AHB master. Frame counters restart on every rising edge of LCDFP; fetching gates on lcd_en and single/dual panel mode.

Parameters:
FIFO_DEPTH, 32, FIFO capacity in 32-bit words
BURST, 8, maximum words per request (power of 2, <= 16)
CNTW, 20, width of per-panel word counters

Ports:
HCLK  in  1  system clock; all logic on rising edge
HRESET  in  1  reset, synchronous, active-high
lcd_en  in  1  LCD enable; low blocks new requests
dual  in  1  1 = dual panel (both FIFOs), 0 = upper panel only
LCDFP  in  1  vertical sync, already in HCLK domain
upbase  in  32  upper panel frame base byte address, bits[1:0] ignored
lpbase  in  32  lower panel frame base byte address, bits[1:0] ignored
frame_words  in  CNTW  words per panel per frame; 0 = fetch nothing
fifo_used1  in  6  upper FIFO occupancy
fifo_used2  in  6  lower FIFO occupancy
req  out  1  burst request to AHB master
req_addr  out  32  burst start byte address, word aligned
req_len  out  5  burst length in words, 1..BURST
req_panel  out  1  0 = upper/FIFO1, 1 = lower/FIFO2
req_ack  in  1  master accepted request (one-cycle pulse)
burst_done  in  1  master finished writing burst into FIFO (one-cycle pulse)
busy  out  1  request outstanding (state REQ or WAIT)
frame_fetched  out  1  one-cycle pulse: all active panels fully fetched

Behaviour:
- Reset values: req=0, req_addr=0, req_len=0, req_panel=0, busy=0, frame_fetched=0.
- Internal reset values: state=IDLE, addr0=addr1=0, rem0=rem1=0, last_panel=1 so panel 0 wins first, fp_d=0, restart_pend=0.
- fp_edge = LCDFP & !fp_d, where fp_d is the registered LCDFP.
- Reload (one cycle):
  - addr0 <= {upbase[31:2],2'b00}; addr1 <= {lpbase[31:2],2'b00}.
  - rem0 <= frame_words.
  - rem1 <= dual ? frame_words : 0.
- Eligibility of panel p: lcd_en & rem_p != 0 & (FIFO_DEPTH - fifo_used_p) >= BURST. Panel 1 additionally requires dual.
- FSM:
  - IDLE:
    - fp_edge -> reload, stay IDLE.
    - Otherwise, if any panel is eligible -> ARB.
  - ARB: one cycle.
    - Select the eligible panel, round-robin with priority to !last_panel.
    - req_len = min(BURST, rem_p); req_addr = addr_p; req_panel = p; assert req -> REQ.
    - If no panel is eligible (lost in between) -> IDLE.
  - REQ:
    - req and all req_* fields hold stable until req_ack.
    - On req_ack: req=0 next cycle, last_panel <= p -> WAIT.
  - WAIT:
    - On burst_done: addr_p += req_len*4 (32-bit wrap), rem_p -= req_len.
    - Then -> IDLE, or -> reload if restart_pend.
- fp_edge in REQ or WAIT sets restart_pend. The outstanding burst is never aborted. Reload occurs on the cycle after burst_done; restart_pend is cleared.
- burst_done and fp_edge in the same WAIT cycle: counter update is discarded, reload wins.
- fp_edge in ARB: request is still issued; restart_pend set.
- Only one request is outstanding at a time. req_ack outside REQ and burst_done outside WAIT are ignored.
- lcd_en falling mid-burst: current burst completes normally; no new ARB until lcd_en=1.
- Last burst of a frame is short when rem_p < BURST; req_len = rem_p.
- frame_fetched: pulses one cycle when a burst_done brings the final active rem to 0.
  - Active rem is rem0 in single-panel mode, rem0 and rem1 in dual mode.
  - Suppressed if a reload happens in the same cycle.
- Fairness: with both panels continuously eligible, grants alternate 0,1,0,1.
- Latency: eligibility in IDLE -> req high 2 cycles later (IDLE->ARB->REQ).
- HRESET asserted at any point (including REQ/WAIT): all state returns to reset values on the next edge; a pending burst is forgotten.

Test Plan:
- Single panel, upbase=0x1000_0000, frame_words=20, BURST=8, FIFO empty, immediate ack/done -> requests (0x1000_0000,8), (0x1000_0020,8), (0x1000_0040,4), all req_panel=0; frame_fetched pulses once, after the third burst_done.
- Dual panel, frame_words=16, both FIFOs empty -> req_panel sequence 0,1,0,1; lower addresses lpbase, lpbase+0x20; frame_fetched only after the fourth done.
- fifo_used1=25 (free 7 < 8), fifo_used2=0 -> only panel 1 requested; set fifo_used1=24 -> panel 0 granted at next ARB.
- LCDFP rising during WAIT, burst_done delayed 5 cycles -> req stays low; after done, next request address = upbase, len = min(8, frame_words). Repeat with LCDFP edge coincident with burst_done -> reload wins, no frame_fetched.
- req_ack withheld 10 cycles -> req, req_addr, req_len, req_panel constant for all 10 cycles; lcd_en=0 during WAIT -> done accepted, no further req.
- HRESET asserted in REQ -> next cycle req=0, busy=0; after release, no request until a LCDFP edge reloads the counters.

Source files
------------

// File: rtl/lcd_fetch_sched.sv
// lcd_fetch_sched: chooses which LCD panel FIFO is refilled next, sizes the
// burst, and hands one request at a time to the AHB master. Per-panel frame
// address and remaining word count restart on each rising edge of LCDFP.
module lcd_fetch_sched #(
  parameter int FIFO_DEPTH = 32,
  parameter int BURST      = 8,
  parameter int CNTW       = 20
) (
  input  logic            HCLK,
  input  logic            HRESET,
  input  logic            lcd_en,
  input  logic            dual,
  input  logic            LCDFP,
  input  logic [31:0]     upbase,
  input  logic [31:0]     lpbase,
  input  logic [CNTW-1:0] frame_words,
  input  logic [5:0]      fifo_used1,
  input  logic [5:0]      fifo_used2,
  output logic            req,
  output logic [31:0]     req_addr,
  output logic [4:0]      req_len,
  output logic            req_panel,
  input  logic            req_ack,
  input  logic            burst_done,
  output logic            busy,
  output logic            frame_fetched
);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_REQ, S_WAIT} state_t;

  // A FIFO can take a full burst when its occupancy is at most this value.
  localparam logic [6:0]      USED_MAX = 7'(FIFO_DEPTH - BURST);
  localparam logic [CNTW-1:0] BURST_W  = CNTW'(BURST);
  localparam logic [4:0]      BURST_L  = 5'(BURST);

  state_t          state, state_d;
  logic [31:0]     addr0, addr1;
  logic [CNTW-1:0] rem0, rem1;
  logic            last_panel;
  logic            fp_d;
  logic            restart_pend;

  logic            fp_edge;
  logic            elig0, elig1, any_elig;
  logic            grant;
  logic [31:0]     sel_addr;
  logic [CNTW-1:0] sel_rem;
  logic [4:0]      sel_len;
  logic [CNTW-1:0] done_rem;
  logic [CNTW-1:0] rem0_after, rem1_after;
  logic            all_done;

  logic do_reload, do_update, do_issue, take_ack, set_pend, clr_pend, ff_d;

  assign fp_edge  = LCDFP & ~fp_d;
  assign elig0    = lcd_en && (rem0 != '0) && ({1'b0, fifo_used1} <= USED_MAX);
  assign elig1    = lcd_en && dual && (rem1 != '0) && ({1'b0, fifo_used2} <= USED_MAX);
  assign any_elig = elig0 | elig1;

  // Round-robin: on a tie the panel that was not served last wins.
  assign grant    = (elig0 && elig1) ? ~last_panel : elig1;
  assign sel_addr = grant ? addr1 : addr0;
  assign sel_rem  = grant ? rem1 : rem0;
  assign sel_len  = (sel_rem >= BURST_W) ? BURST_L : sel_rem[4:0];

  // Counter values as they will be once the outstanding burst retires.
  assign done_rem   = (req_panel ? rem1 : rem0) - CNTW'(req_len);
  assign rem0_after = req_panel ? rem0 : done_rem;
  assign rem1_after = req_panel ? done_rem : rem1;
  assign all_done   = (rem0_after == '0) && (!dual || (rem1_after == '0));

  assign req  = (state == S_REQ);
  assign busy = (state == S_REQ) || (state == S_WAIT);

  // State register.
  always_ff @(posedge HCLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (HRESET) state <= S_IDLE;
    else        state <= state_d;
  end

  // Next-state decode and datapath strobes.
  always_comb begin
    // NOTE: every signal gets a default first so no path infers a latch.
    state_d   = state;
    do_reload = 1'b0;
    do_update = 1'b0;
    do_issue  = 1'b0;
    take_ack  = 1'b0;
    set_pend  = 1'b0;
    clr_pend  = 1'b0;
    ff_d      = 1'b0;
    case (state)
      S_IDLE: begin
        if (fp_edge)       do_reload = 1'b1;
        else if (any_elig) state_d   = S_ARB;
      end
      S_ARB: begin
        if (any_elig) begin
          do_issue = 1'b1;
          set_pend = fp_edge;
          state_d  = S_REQ;
        end else begin
          // Nothing to issue, so a frame restart can be taken right away.
          do_reload = fp_edge;
          state_d   = S_IDLE;
        end
      end
      S_REQ: begin
        set_pend = fp_edge;
        if (req_ack) begin
          take_ack = 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (burst_done) begin
          clr_pend = 1'b1;
          state_d  = S_IDLE;
          // A pending or coincident frame restart discards the count update.
          if (restart_pend || fp_edge) begin
            do_reload = 1'b1;
          end else begin
            do_update = 1'b1;
            ff_d      = all_done;
          end
        end else begin
          set_pend = fp_edge;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Frame counters, request fields, arbitration history and edge detect.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      addr0         <= '0;
      addr1         <= '0;
      rem0          <= '0;
      rem1          <= '0;
      last_panel    <= 1'b1;
      fp_d          <= 1'b0;
      restart_pend  <= 1'b0;
      req_addr      <= '0;
      req_len       <= '0;
      req_panel     <= 1'b0;
      frame_fetched <= 1'b0;
    end else begin
      fp_d          <= LCDFP;
      frame_fetched <= ff_d;

      if (clr_pend)      restart_pend <= 1'b0;
      else if (set_pend) restart_pend <= 1'b1;

      if (do_reload) begin
        addr0 <= {upbase[31:2], 2'b00};
        addr1 <= {lpbase[31:2], 2'b00};
        rem0  <= frame_words;
        rem1  <= dual ? frame_words : '0;
      end else if (do_update) begin
        if (req_panel) begin
          addr1 <= addr1 + {25'd0, req_len, 2'b00};
          rem1  <= done_rem;
        end else begin
          addr0 <= addr0 + {25'd0, req_len, 2'b00};
          rem0  <= done_rem;
        end
      end

      if (do_issue) begin
        req_addr  <= sel_addr;
        req_len   <= sel_len;
        req_panel <= grant;
      end

      if (take_ack) last_panel <= req_panel;
    end
  end

endmodule

// File: tb/tb_lcd_fetch_sched.sv
// tb_lcd_fetch_sched: directed stimulus with a transaction-level model of the
// fetch scheduler (frame counters, round-robin history, restart handling)
// checked against the DUT on every cycle, plus literal request expectations.
module tb_lcd_fetch_sched;

  localparam int FIFO_DEPTH = 32;
  localparam int BURST      = 8;
  localparam int CNTW       = 20;

  logic            HCLK = 1'b0;
  logic            HRESET, lcd_en, dual, LCDFP;
  logic [31:0]     upbase, lpbase;
  logic [CNTW-1:0] frame_words;
  logic [5:0]      fifo_used1, fifo_used2;
  logic            req, req_panel, req_ack, burst_done, busy, frame_fetched;
  logic [31:0]     req_addr;
  logic [4:0]      req_len;

  always #5 HCLK = ~HCLK;

  lcd_fetch_sched #(.FIFO_DEPTH(FIFO_DEPTH), .BURST(BURST), .CNTW(CNTW)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .lcd_en(lcd_en), .dual(dual), .LCDFP(LCDFP),
    .upbase(upbase), .lpbase(lpbase), .frame_words(frame_words),
    .fifo_used1(fifo_used1), .fifo_used2(fifo_used2),
    .req(req), .req_addr(req_addr), .req_len(req_len), .req_panel(req_panel),
    .req_ack(req_ack), .burst_done(burst_done), .busy(busy),
    .frame_fetched(frame_fetched)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        panel;
    logic [31:0] addr;
    logic [4:0]  len;
  } rec_t;

  rec_t log_q[$];
  int   ff_count = 0;

  // ---------------- model ----------------
  logic [31:0]     m_addr [2];
  logic [CNTW-1:0] m_rem  [2];
  bit              m_last = 1'b1;
  bit              m_pend = 1'b0;
  bit              m_wait = 1'b0;
  bit              m_after_rst = 1'b1;
  bit              m_exp_ff = 1'b0;
  bit              m_fp_prev = 1'b0;
  bit              prev_req = 1'b0;
  bit              p_any = 1'b0;
  bit              p_panel = 1'b0;
  logic [31:0]     p_addr = '0;
  logic [4:0]      p_len = '0;
  bit              h_panel = 1'b0;
  logic [31:0]     h_addr = '0;
  logic [4:0]      h_len = '0;

  initial begin
    m_addr[0] = '0; m_addr[1] = '0;
    m_rem[0]  = '0; m_rem[1]  = '0;
  end

  // Outputs settle after the rising edge; compare and advance on the falling edge.
  always @(negedge HCLK) begin : monitor
    bit fpe, e0, e1;
    if (m_after_rst) begin
      check("rst_req",       32'(req),       32'(0));
      check("rst_busy",      32'(busy),      32'(0));
      check("rst_req_addr",  req_addr,       32'(0));
      check("rst_req_len",   32'(req_len),   32'(0));
      check("rst_req_panel", 32'(req_panel), 32'(0));
    end
    check("frame_fetched", 32'(frame_fetched), 32'(m_exp_ff));
    if (frame_fetched === 1'b1) ff_count++;
    check("req_while_waiting", 32'(req === 1'b1 && m_wait), 32'(0));
    check("busy", 32'(busy), 32'(req === 1'b1 || m_wait));
    if (req === 1'b1) begin
      if (!prev_req) begin
        check("req_allowed", 32'(p_any), 32'(1));
        h_panel = p_panel;
        h_addr  = p_addr;
        h_len   = p_len;
        log_q.push_back('{panel: req_panel, addr: req_addr, len: req_len});
      end
      check("req_panel", 32'(req_panel), 32'(h_panel));
      check("req_addr",  req_addr,       h_addr);
      check("req_len",   32'(req_len),   32'(h_len));
    end

    // Advance the model with the inputs the next rising edge will see.
    m_after_rst = 1'b0;
    m_exp_ff    = 1'b0;
    fpe         = LCDFP && !m_fp_prev;
    m_fp_prev   = LCDFP;
    if (HRESET) begin
      m_addr[0] = '0; m_addr[1] = '0;
      m_rem[0]  = '0; m_rem[1]  = '0;
      m_last = 1'b1; m_pend = 1'b0; m_wait = 1'b0;
      m_fp_prev = 1'b0; m_after_rst = 1'b1;
      prev_req = 1'b0;
    end else begin
      if (m_wait && burst_done) begin
        if (m_pend || fpe) begin
          m_addr[0] = {upbase[31:2], 2'b00};
          m_addr[1] = {lpbase[31:2], 2'b00};
          m_rem[0]  = frame_words;
          m_rem[1]  = dual ? frame_words : '0;
        end else begin
          m_addr[h_panel] = m_addr[h_panel] + 32'(h_len) * 4;
          m_rem[h_panel]  = m_rem[h_panel] - CNTW'(h_len);
          m_exp_ff = (m_rem[0] == 0) && (!dual || m_rem[1] == 0);
        end
        m_wait = 1'b0;
        m_pend = 1'b0;
      end else if (req === 1'b1 && req_ack) begin
        m_wait = 1'b1;
        m_last = h_panel;
        if (fpe) m_pend = 1'b1;
      end else if (fpe) begin
        if (req === 1'b1 || m_wait) begin
          m_pend = 1'b1;
        end else begin
          m_addr[0] = {upbase[31:2], 2'b00};
          m_addr[1] = {lpbase[31:2], 2'b00};
          m_rem[0]  = frame_words;
          m_rem[1]  = dual ? frame_words : '0;
        end
      end
      prev_req = (req === 1'b1);
    end
    e0 = lcd_en && (m_rem[0] != 0) && ((FIFO_DEPTH - int'(fifo_used1)) >= BURST);
    e1 = lcd_en && dual && (m_rem[1] != 0) && ((FIFO_DEPTH - int'(fifo_used2)) >= BURST);
    p_any   = e0 || e1;
    p_panel = (e0 && e1) ? !m_last : e1;
    p_addr  = m_addr[p_panel];
    p_len   = (m_rem[p_panel] < CNTW'(BURST)) ? m_rem[p_panel][4:0] : 5'(BURST);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge HCLK);
      #1;
    end
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    tick(2);
    HRESET = 1'b0;
    tick(1);
  endtask

  task automatic fp_pulse();
    LCDFP = 1'b1;
    tick(1);
    LCDFP = 1'b0;
    tick(1);
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    check("req_timeout", 32'(ok), 32'(1));
  endtask

  task automatic pulse_ack();
    req_ack = 1'b1;
    tick(1);
    req_ack = 1'b0;
  endtask

  task automatic pulse_done();
    burst_done = 1'b1;
    tick(1);
    burst_done = 1'b0;
  endtask

  task automatic do_burst();
    bit ok;
    wait_req(ok);
    if (ok) begin
      pulse_ack();
      pulse_done();
    end
  endtask

  task automatic expect_req(input string name, input int idx, input logic panel,
                            input logic [31:0] addr, input logic [4:0] len);
    if (idx < log_q.size()) begin
      check({name, "_panel"}, 32'(log_q[idx].panel), 32'(panel));
      check({name, "_addr"},  log_q[idx].addr,       addr);
      check({name, "_len"},   32'(log_q[idx].len),   32'(len));
    end else begin
      check({name, "_present"}, 32'(log_q.size()), 32'(idx + 1));
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int  base, ffb;
    bit  ok;
    HRESET = 1'b1; lcd_en = 1'b0; dual = 1'b0; LCDFP = 1'b0;
    upbase = '0; lpbase = '0; frame_words = '0;
    fifo_used1 = '0; fifo_used2 = '0; req_ack = 1'b0; burst_done = 1'b0;
    tick(2);
    check("reset_req",       32'(req),           32'(0));
    check("reset_busy",      32'(busy),          32'(0));
    check("reset_addr",      req_addr,           32'(0));
    check("reset_len",       32'(req_len),       32'(0));
    check("reset_ff",        32'(frame_fetched), 32'(0));
    HRESET = 1'b0;
    tick(1);

    // Single panel, 20 words: 8 + 8 + 4.
    do_reset();
    base = log_q.size(); ffb = ff_count;
    upbase = 32'h1000_0000; frame_words = 20; lcd_en = 1'b1; dual = 1'b0;
    LCDFP = 1'b1;
    tick(1);
    LCDFP = 1'b0;
    tick(1);
    check("t1_latency_arb", 32'(req), 32'(0));
    tick(1);
    check("t1_latency_req", 32'(req), 32'(1));
    repeat (3) do_burst();
    tick(5);
    check("t1_count", 32'(log_q.size() - base), 32'(3));
    expect_req("t1_r0", base + 0, 1'b0, 32'h1000_0000, 5'd8);
    expect_req("t1_r1", base + 1, 1'b0, 32'h1000_0020, 5'd8);
    expect_req("t1_r2", base + 2, 1'b0, 32'h1000_0040, 5'd4);
    check("t1_ff", 32'(ff_count - ffb), 32'(1));

    // Dual panel, 16 words each: strict alternation.
    do_reset();
    base = log_q.size(); ffb = ff_count;
    upbase = 32'h2000_0000; lpbase = 32'h3000_0103; frame_words = 16; dual = 1'b1;
    fp_pulse();
    repeat (3) do_burst();
    tick(3);
    check("t2_ff_early", 32'(ff_count - ffb), 32'(0));
    do_burst();
    tick(3);
    check("t2_ff", 32'(ff_count - ffb), 32'(1));
    expect_req("t2_r0", base + 0, 1'b0, 32'h2000_0000, 5'd8);
    expect_req("t2_r1", base + 1, 1'b1, 32'h3000_0100, 5'd8);
    expect_req("t2_r2", base + 2, 1'b0, 32'h2000_0020, 5'd8);
    expect_req("t2_r3", base + 3, 1'b1, 32'h3000_0120, 5'd8);

    // Upper FIFO one word short of a burst; freed after the first grant.
    do_reset();
    base = log_q.size(); ffb = ff_count;
    lpbase = 32'h3000_0100; fifo_used1 = 6'd25; fifo_used2 = 6'd0;
    fp_pulse();
    do_burst();
    fifo_used1 = 6'd24;
    repeat (3) do_burst();
    tick(3);
    expect_req("t3_r0", base + 0, 1'b1, 32'h3000_0100, 5'd8);
    expect_req("t3_r1", base + 1, 1'b0, 32'h2000_0000, 5'd8);
    expect_req("t3_r2", base + 2, 1'b1, 32'h3000_0120, 5'd8);
    expect_req("t3_r3", base + 3, 1'b0, 32'h2000_0020, 5'd8);
    check("t3_ff", 32'(ff_count - ffb), 32'(1));
    fifo_used1 = 6'd0;

    // Frame restart during WAIT, done delayed 5 cycles.
    do_reset();
    base = log_q.size(); ffb = ff_count;
    dual = 1'b0; upbase = 32'h4000_0000; frame_words = 12;
    fp_pulse();
    wait_req(ok);
    if (ok) pulse_ack();
    LCDFP = 1'b1;
    tick(1);
    LCDFP = 1'b0;
    repeat (4) begin
      check("t4_req_low", 32'(req), 32'(0));
      tick(1);
    end
    pulse_done();
    repeat (2) do_burst();
    tick(3);
    expect_req("t4_r0", base + 0, 1'b0, 32'h4000_0000, 5'd8);
    expect_req("t4_r1", base + 1, 1'b0, 32'h4000_0000, 5'd8);
    expect_req("t4_r2", base + 2, 1'b0, 32'h4000_0020, 5'd4);
    check("t4_ff", 32'(ff_count - ffb), 32'(1));

    // Frame restart coincident with the final burst_done.
    do_reset();
    base = log_q.size(); ffb = ff_count;
    upbase = 32'h4800_0000; frame_words = 8;
    fp_pulse();
    wait_req(ok);
    if (ok) pulse_ack();
    LCDFP = 1'b1; burst_done = 1'b1;
    tick(1);
    LCDFP = 1'b0; burst_done = 1'b0;
    tick(3);
    check("t4b_no_ff", 32'(ff_count - ffb), 32'(0));
    do_burst();
    tick(3);
    expect_req("t4b_r0", base + 0, 1'b0, 32'h4800_0000, 5'd8);
    expect_req("t4b_r1", base + 1, 1'b0, 32'h4800_0000, 5'd8);
    check("t4b_ff", 32'(ff_count - ffb), 32'(1));

    // Ack withheld 10 cycles, then lcd_en dropped during WAIT.
    do_reset();
    base = log_q.size(); ffb = ff_count;
    upbase = 32'h5000_0000; frame_words = 16;
    fp_pulse();
    wait_req(ok);
    repeat (10) begin
      check("t5_hold_req",   32'(req),       32'(1));
      check("t5_hold_addr",  req_addr,       32'h5000_0000);
      check("t5_hold_len",   32'(req_len),   32'(8));
      check("t5_hold_panel", 32'(req_panel), 32'(0));
      tick(1);
    end
    pulse_ack();
    lcd_en = 1'b0;
    tick(1);
    pulse_done();
    tick(10);
    check("t5_no_req", 32'(log_q.size() - base), 32'(1));
    check("t5_idle",   32'(busy),                32'(0));
    lcd_en = 1'b1;
    do_burst();
    tick(3);
    expect_req("t5_r1", base + 1, 1'b0, 32'h5000_0020, 5'd8);
    check("t5_ff", 32'(ff_count - ffb), 32'(1));

    // Reset while a request is outstanding.
    do_reset();
    base = log_q.size();
    upbase = 32'h6000_0000; frame_words = 16;
    fp_pulse();
    wait_req(ok);
    HRESET = 1'b1;
    tick(1);
    check("t6_req",  32'(req),  32'(0));
    check("t6_busy", 32'(busy), 32'(0));
    HRESET = 1'b0;
    tick(10);
    check("t6_no_req", 32'(log_q.size() - base), 32'(1));
    fp_pulse();
    do_burst();
    tick(2);
    expect_req("t6_r0", base + 0, 1'b0, 32'h6000_0000, 5'd8);
    expect_req("t6_r1", base + 1, 1'b0, 32'h6000_0000, 5'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
